serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor built around a single full-subtractor cell. It is the subtract-direction counterpart to the full-adder datapath. It accepts one operand pair over a valid/ready handshake and computes `a - b` LSB-first, one bit per clock. It presents the difference and final borrow on a held valid/ready output. It targets area-constrained arithmetic paths where WIDTH-cycle latency is acceptable.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range ≥ 2.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept operands.
- `a` in WIDTH: minuend, unsigned (two's complement when overflow is enabled).
- `b` in WIDTH: subtrahend.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `diff` out WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow` out 1: final borrow-out; 1 iff `a < b` unsigned.
- `ovf` out 1: signed overflow; port exists only with `SERIAL_SUB_OVF_EN`.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, the block loads `a` and `b` into shift registers `a_sr` and `b_sr`.
  - It clears `borrow_q`, clears the bit counter, and moves to RUN.
  - Inputs are not sampled at any other time.
- **RUN**
  - The cell computes from `a_sr[0]`, `b_sr[0]` and `bin` = `borrow_q`:
    - `d` = `a ^ b ^ bin`
    - `bout` = `(~a & b) | (~(a ^ b) & bin)`
  - `d` shifts into `diff_sr` at the MSB, with the register shifting right.
  - `a_sr` and `b_sr` shift right, `borrow_q` <= `bout`, and the counter increments.
  - When the counter reaches WIDTH-1, the FSM moves to DONE.
- **DONE**
  - `out_valid` = 1.
  - `diff` = `diff_sr` and `borrow` = `borrow_q`; both stay stable while `out_valid && !out_ready`.
  - On `out_ready`, the FSM returns to IDLE.
- `in_ready` = 0 in RUN and DONE. `in_valid` in those states is ignored and not queued.
- The counter is `$clog2(WIDTH)` bits wide. It wraps to 0 on load and never counts past WIDTH-1.
- Reset mid-operation abandons the operation: state goes to IDLE, no `out_valid` pulse is produced, and the partial result is discarded.
- Reset values:
  - state IDLE
  - `out_valid` 0
  - `diff` 0
  - `borrow` 0
  - `ovf` 0
  - `in_ready` 0 while `rst` is high, then 1 in the first cycle after reset deasserts.

## Timing
- Acceptance at edge k.
- RUN occupies edges k+1 … k+WIDTH.
- `out_valid` is high after edge k+WIDTH, giving latency of WIDTH cycles from acceptance.
- Minimum issue interval is WIDTH+2 cycles: one IDLE cycle, WIDTH RUN cycles, one DONE cycle with `out_ready` = 1.
- `out_valid`, `diff`, `borrow` and `ovf` are register outputs.
- `in_ready` is decoded from state only. There is no combinational path from `out_ready` to `in_ready`.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - The `ovf` port is present.
  - The MSB operand bits are captured at load.
  - In DONE, `ovf` = `(a_msb != b_msb) && (diff[WIDTH-1] != a_msb)`; it is held with `diff`.
- `SERIAL_SUB_OVF_EN` undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package `serial_sub_pkg`:
  - state enum `sub_state_t` {IDLE, RUN, DONE}
  - default width constant `SUB_WIDTH_DEFAULT` = 8
- Sub-module `full_subtractor`:
  - purely combinational, one bit
  - inputs `A`, `B`, `Bin`; outputs `D`, `Bout`
  - instantiated once in the datapath
- Top level holds the FSM, counter, shift registers and handshake.

## Test plan
1. **Basic subtract with latency check.** WIDTH=8, a=0x5A, b=0x23, `out_ready`=1 → `diff`=0x37, `borrow`=0, `out_valid` rises exactly 8 cycles after acceptance and is high for 1 cycle.
2. **Borrow cases.** a=0x10, b=0x20 → `diff`=0xF0, `borrow`=1. a=0x00, b=0xFF → `diff`=0x01, `borrow`=1. a=b=0xFF → `diff`=0x00, `borrow`=0.
3. **Overflow, with `SERIAL_SUB_OVF_EN`.** a=0x80, b=0x01 → `diff`=0x7F, `ovf`=1, `borrow`=0. a=0x05, b=0x03 → `ovf`=0.
4. **Output backpressure.** Hold `out_ready`=0 for 5 cycles in DONE → `out_valid`, `diff` and `borrow` are unchanged; `in_ready`=0; an `in_valid` pulse with a=0x11 is ignored. Raising `out_ready` → IDLE next cycle.
5. **Reset mid-RUN.** Assert `rst` in the third RUN cycle → IDLE after that edge, no `out_valid`, `diff`=0. A following a=0x09, b=0x04 → `diff`=0x05.
6. **Back-to-back.** Hold `in_valid` high with `out_ready`=1 → operations complete every WIDTH+2 cycles with correct results, no operand lost or duplicated. Also run with WIDTH=2: a=2, b=3 → `diff`=3, `borrow`=1.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional signed-overflow flag is enabled by defining SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
);

  // Valid/ready: a transfer happens on a rising edge where valid && ready.
  // A producer holds valid and its payload stable until that edge; the
  // result side keeps out_valid/diff/borrow/ovf stable until out_ready.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: D = A - B - Bin, Bout is the borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor computing a - b LSB-first through one full-subtractor cell.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus,
  output sub_state_t          dbg_state
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow_q;
  logic             d;
  logic             bout;
  logic             last_bit;

  full_subtractor u_cell (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Bin  (borrow_q),
    .D    (d),
    .Bout (bout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // The final cell output is the result MSB, so overflow is settled on the last RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state == S_IDLE && bus.in_valid) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
      ovf_q <= 1'b0;
    end else if (state == S_RUN && last_bit) begin
      ovf_q <= (a_msb != b_msb) && (d != a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            borrow_q <= 1'b0;
            cnt      <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          diff_sr  <= {d, diff_sr[WIDTH-1:1]};
          borrow_q <= bout;
          if (last_bit) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Ready is low throughout reset so nothing is accepted before the block is live.
  assign bus.in_ready  = (state == S_IDLE) && !rst;
  assign bus.out_valid = (state == S_DONE);
  assign bus.diff      = diff_sr;
  assign bus.borrow    = borrow_q;
  assign dbg_state     = sub_state_t'(state);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=2.
// Define SERIAL_SUB_OVF_EN to also check the ovf output.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(2)) bus2 ();
  sub_state_t st8;
  sub_state_t st2;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus8),
    .dbg_state (st8)
  );

  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .dbg_state (st2)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } vec_t;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, result packed {ovf, borrow, diff}.
  function automatic logic [9:0] ref_model(input int w, input int a, input int b);
    int m, dv, sa, sb, r;
    logic bo, ov;
    m  = 1 << w;
    dv = a - b;
    bo = (a < b);
    if (dv < 0) dv += m;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    r  = sa - sb;
    ov = (r < -(m / 2)) || (r >= m / 2);
    return {ov, bo, 8'(dv)};
  endfunction

  function automatic logic ovf8();
`ifdef SERIAL_SUB_OVF_EN
    return bus8.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver tasks (called #1 after a rising edge) ----------------
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b);
    int guard = 0;
    while (!bus8.in_ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    check("in_ready_wait8", bus8.in_ready, 1);
    bus8.a = a;
    bus8.b = b;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (!bus8.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] dv, output logic bo, output logic ov,
                         output int lat);
    start_op8(a, b);
    wait_done8(lat);
    dv = bus8.diff;
    bo = bus8.borrow;
    ov = ovf8();
    @(posedge clk); #1;
    check("out_valid_one_cycle", bus8.out_valid, 0);
  endtask

  task automatic run_op2(input int a, input int b);
    logic [9:0] e;
    int guard = 0;
    int lat = 0;
    e = ref_model(2, a, b);
    while (!bus2.in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    bus2.a = 2'(a);
    bus2.b = 2'(b);
    bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    while (!bus2.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("w2_latency", lat, 2);
    check("w2_diff", bus2.diff, e[1:0]);
    check("w2_borrow", bus2.borrow, e[8]);
`ifdef SERIAL_SUB_OVF_EN
    check("w2_ovf", bus2.ovf, e[9]);
`endif
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[7];
    logic [7:0] dv;
    logic bo, ov;
    int lat, cnt, cyc, got, idx, last_done;
    logic acc;
    logic [9:0] e;
    logic [7:0] ra[20];
    logic [7:0] rb[20];

    vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[6] = '{8'h09, 8'h04, 8'h05, 1'b0, 1'b0};

    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus8.in_ready, 0);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_diff", bus8.diff, 0);
    check("rst_borrow", bus8.borrow, 0);
    check("rst_state", st8, IDLE);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", bus8.ovf, 0);
`endif
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus8.in_ready, 1);
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i]) begin
      run_op8(vecs[i].a, vecs[i].b, dv, bo, ov, lat);
      check("tbl_latency", lat, 8);
      check("tbl_diff", dv, vecs[i].diff);
      check("tbl_borrow", bo, vecs[i].borrow);
`ifdef SERIAL_SUB_OVF_EN
      check("tbl_ovf", ov, vecs[i].ovf);
`endif
    end

    // Output backpressure; a stray in_valid during DONE must be dropped
    bus8.out_ready = 1'b0;
    start_op8(8'h3C, 8'h4D);
    wait_done8(lat);
    check("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", bus8.out_valid, 1);
      check("bp_diff", bus8.diff, 8'hEF);
      check("bp_borrow", bus8.borrow, 1);
      check("bp_in_ready", bus8.in_ready, 0);
      if (i == 1) begin
        bus8.a = 8'h11; bus8.b = 8'h01; bus8.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_state", st8, IDLE);
    check("bp_release_valid", bus8.out_valid, 0);
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus8.out_valid) cnt++;
    end
    check("bp_ignored_input", cnt, 0);

    // Reset in the third RUN cycle
    start_op8(8'hAA, 8'h55);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_state", st8, IDLE);
    check("midrst_out_valid", bus8.out_valid, 0);
    check("midrst_diff", bus8.diff, 0);
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus8.out_valid) cnt++;
    end
    check("midrst_no_result", cnt, 0);
    run_op8(8'h09, 8'h04, dv, bo, ov, lat);
    check("midrst_after_diff", dv, 8'h05);
    check("midrst_after_borrow", bo, 0);

    // Back-to-back random operands with in_valid held high
    foreach (ra[i]) begin
      ra[i] = 8'($urandom_range(0, 255));
      rb[i] = 8'($urandom_range(0, 255));
    end
    idx = 0; got = 0; cyc = 0; last_done = -1;
    bus8.a = ra[0]; bus8.b = rb[0]; bus8.in_valid = 1'b1;
    while (got < 20 && cyc < 600) begin
      acc = bus8.in_valid && bus8.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        exp_q.push_back(ref_model(8, int'(bus8.a), int'(bus8.b)));
        idx++;
        if (idx < 20) begin
          bus8.a = ra[idx]; bus8.b = rb[idx];
        end else begin
          bus8.in_valid = 1'b0;
        end
      end
      if (bus8.out_valid) begin
        got++;
        check("b2b_inflight", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("b2b_diff", bus8.diff, e[7:0]);
          check("b2b_borrow", bus8.borrow, e[8]);
`ifdef SERIAL_SUB_OVF_EN
          check("b2b_ovf", bus8.ovf, e[9]);
`endif
        end
        if (last_done >= 0) check("b2b_interval", cyc - last_done, 10);
        last_done = cyc;
      end
    end
    bus8.in_valid = 1'b0;
    check("b2b_completed", got, 20);
    check("b2b_accepted", idx, 20);

    // WIDTH=2: hand case then every operand pair
    run_op2(2, 3);
    check("w2_hand_diff", bus2.diff, 2'd3);
    check("w2_hand_borrow", bus2.borrow, 1);
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        run_op2(x, y);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
